// File: rtl/ddr4_ui_arbiter.sv
// Two-client round-robin arbiter for the MIG DDR4 app_* interface.
// Read returns are steered back to the issuing client by an in-order tag FIFO.
module ddr4_ui_arbiter #(
   parameter int ADDR_W    = 29,
   parameter int DATA_W    = 128,
   parameter int TAG_DEPTH = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                calib_done,
   input  logic                c0_req,
   input  logic                c1_req,
   output logic                c0_gnt,
   output logic                c1_gnt,
   input  logic                c0_app_en,
   input  logic [2:0]          c0_app_cmd,
   input  logic [ADDR_W-1:0]   c0_app_addr,
   output logic                c0_app_rdy,
   input  logic                c0_app_wdf_wren,
   input  logic                c0_app_wdf_end,
   input  logic [DATA_W-1:0]   c0_app_wdf_data,
   output logic                c0_app_wdf_rdy,
   output logic [DATA_W-1:0]   c0_rd_data,
   output logic                c0_rd_valid,
   output logic                c0_rd_end,
   input  logic                c1_app_en,
   input  logic [2:0]          c1_app_cmd,
   input  logic [ADDR_W-1:0]   c1_app_addr,
   output logic                c1_app_rdy,
   input  logic                c1_app_wdf_wren,
   input  logic                c1_app_wdf_end,
   input  logic [DATA_W-1:0]   c1_app_wdf_data,
   output logic                c1_app_wdf_rdy,
   output logic [DATA_W-1:0]   c1_rd_data,
   output logic                c1_rd_valid,
   output logic                c1_rd_end,
   output logic                app_en,
   output logic [2:0]          app_cmd,
   output logic [ADDR_W-1:0]   app_addr,
   input  logic                app_rdy,
   output logic                app_wdf_wren,
   output logic                app_wdf_end,
   output logic [DATA_W-1:0]   app_wdf_data,
   output logic [DATA_W/8-1:0] app_wdf_mask,
   input  logic                app_wdf_rdy,
   input  logic [DATA_W-1:0]   app_rd_data,
   input  logic                app_rd_data_end,
   input  logic                app_rd_data_valid,
   output logic                tag_err
);

   localparam int TAG_AW = $clog2(TAG_DEPTH);
   localparam logic [2:0] CMD_RD = 3'b001;

   typedef enum logic [1:0] {IDLE, GNT0, GNT1, TURN} state_t;

   state_t              state_q, state_d;
   logic                rr_q, rr_d;
   logic [TAG_DEPTH-1:0] tag_mem_q;
   logic [TAG_AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [TAG_AW:0]     cnt_q;
   logic                tag_err_q;

   logic                gnt0, gnt1, full, empty, head;
   logic                sel_en, sel_wren, sel_wend, rd_block, push, pop;
   logic [2:0]          sel_cmd;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      unique case (state_q)
         IDLE: begin
            if (calib_done) begin
               if (c0_req && (!c1_req || !rr_q)) begin
                  state_d = GNT0;
                  rr_d    = 1'b1;
               end else if (c1_req) begin
                  state_d = GNT1;
                  rr_d    = 1'b0;
               end
            end
         end
         GNT0:    if (!c0_req) state_d = TURN;
         GNT1:    if (!c1_req) state_d = TURN;
         default: state_d = IDLE;
      endcase
   end

   assign gnt0  = (state_q == GNT0);
   assign gnt1  = (state_q == GNT1);
   assign full  = (cnt_q == (TAG_AW+1)'(TAG_DEPTH));
   assign empty = (cnt_q == '0);

   always_comb begin
      sel_en    = 1'b0;
      sel_cmd   = '0;
      sel_addr  = '0;
      sel_wren  = 1'b0;
      sel_wend  = 1'b0;
      sel_wdata = '0;
      if (gnt0) begin
         sel_en    = c0_app_en;
         sel_cmd   = c0_app_cmd;
         sel_addr  = c0_app_addr;
         sel_wren  = c0_app_wdf_wren;
         sel_wend  = c0_app_wdf_end;
         sel_wdata = c0_app_wdf_data;
      end else if (gnt1) begin
         sel_en    = c1_app_en;
         sel_cmd   = c1_app_cmd;
         sel_addr  = c1_app_addr;
         sel_wren  = c1_app_wdf_wren;
         sel_wend  = c1_app_wdf_end;
         sel_wdata = c1_app_wdf_data;
      end
   end

   // A full tag FIFO only holds back reads; writes still flow.
   assign rd_block = full && (sel_cmd == CMD_RD);

   assign app_en       = sel_en & ~rd_block;
   assign app_cmd      = sel_cmd;
   assign app_addr     = sel_addr;
   assign app_wdf_wren = sel_wren;
   assign app_wdf_end  = sel_wend;
   assign app_wdf_data = sel_wdata;
   assign app_wdf_mask = '0;

   assign c0_gnt         = gnt0;
   assign c1_gnt         = gnt1;
   assign c0_app_rdy     = gnt0 & app_rdy & ~rd_block;
   assign c1_app_rdy     = gnt1 & app_rdy & ~rd_block;
   assign c0_app_wdf_rdy = gnt0 & app_wdf_rdy;
   assign c1_app_wdf_rdy = gnt1 & app_wdf_rdy;

   assign push = app_en & app_rdy & (sel_cmd == CMD_RD);
   assign pop  = app_rd_data_valid & app_rd_data_end & ~empty;
   assign head = tag_mem_q[rd_ptr_q];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_mem_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         tag_err_q <= 1'b0;
      end else begin
         if (push) begin
            tag_mem_q[wr_ptr_q] <= gnt1;
            wr_ptr_q            <= wr_ptr_q + TAG_AW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + TAG_AW'(1);
         if (push && !pop)      cnt_q <= cnt_q + (TAG_AW+1)'(1);
         else if (pop && !push) cnt_q <= cnt_q - (TAG_AW+1)'(1);
         if (app_rd_data_valid && empty) tag_err_q <= 1'b1;
      end
   end

   assign tag_err     = tag_err_q;
   assign c0_rd_data  = app_rd_data;
   assign c1_rd_data  = app_rd_data;
   assign c0_rd_valid = app_rd_data_valid & ~empty & ~head;
   assign c1_rd_valid = app_rd_data_valid & ~empty & head;
   assign c0_rd_end   = app_rd_data_valid & app_rd_data_end & ~empty & ~head;
   assign c1_rd_end   = app_rd_data_valid & app_rd_data_end & ~empty & head;

endmodule

// File: tb/tb_ddr4_ui_arbiter.sv
// Bench for ddr4_ui_arbiter: datapath vector table plus scoreboarded read-return routing.
module tb_ddr4_ui_arbiter;

   localparam int ADDR_W = 29;
   localparam int DATA_W = 128;
   localparam int TAG_DEPTH = 32;

   logic clk, reset, calib_done;
   logic [1:0] req, gnt, app_rdy_o, wdf_rdy_o, rvalid, rend;
   logic [1:0] c_en, c_wren, c_wend;
   logic [2:0] c_cmd [2];
   logic [ADDR_W-1:0] c_addr [2];
   logic [DATA_W-1:0] c_wdata [2];
   logic [DATA_W-1:0] c0_rd_data, c1_rd_data;
   logic app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic [2:0] app_cmd;
   logic [ADDR_W-1:0] app_addr;
   logic [DATA_W-1:0] app_wdf_data, app_rd_data;
   logic [DATA_W/8-1:0] app_wdf_mask;
   logic app_rd_data_end, app_rd_data_valid, tag_err;

   int total = 0;
   int bad = 0;
   int sb[$];

   ddr4_ui_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
      .clk(clk), .reset(reset), .calib_done(calib_done),
      .c0_req(req[0]), .c1_req(req[1]), .c0_gnt(gnt[0]), .c1_gnt(gnt[1]),
      .c0_app_en(c_en[0]), .c0_app_cmd(c_cmd[0]), .c0_app_addr(c_addr[0]), .c0_app_rdy(app_rdy_o[0]),
      .c0_app_wdf_wren(c_wren[0]), .c0_app_wdf_end(c_wend[0]), .c0_app_wdf_data(c_wdata[0]),
      .c0_app_wdf_rdy(wdf_rdy_o[0]), .c0_rd_data(c0_rd_data), .c0_rd_valid(rvalid[0]), .c0_rd_end(rend[0]),
      .c1_app_en(c_en[1]), .c1_app_cmd(c_cmd[1]), .c1_app_addr(c_addr[1]), .c1_app_rdy(app_rdy_o[1]),
      .c1_app_wdf_wren(c_wren[1]), .c1_app_wdf_end(c_wend[1]), .c1_app_wdf_data(c_wdata[1]),
      .c1_app_wdf_rdy(wdf_rdy_o[1]), .c1_rd_data(c1_rd_data), .c1_rd_valid(rvalid[1]), .c1_rd_end(rend[1]),
      .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
      .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
      .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
      .app_rd_data(app_rd_data), .app_rd_data_end(app_rd_data_end),
      .app_rd_data_valid(app_rd_data_valid), .tag_err(tag_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic en; logic [2:0] cmd; logic c1en; logic rdy; logic wrdy; logic wren;
      logic x_en; logic [2:0] x_cmd; logic x_rdy0; logic x_rdy1; logic x_wrdy0; logic x_wren;
   } vec_t;
   vec_t vt [6];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      req = '0; c_en = '0; c_wren = '0; c_wend = '0;
      for (int i = 0; i < 2; i++) begin
         c_cmd[i] = '0; c_addr[i] = '0; c_wdata[i] = '0;
      end
      app_rdy = 1'b1; app_wdf_rdy = 1'b1;
      app_rd_data = '0; app_rd_data_end = 1'b0; app_rd_data_valid = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      sb.delete();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic wait_gnt(input int id);
      for (int i = 0; i < 20; i++) begin
         if (gnt[id]) break;
         tick();
      end
      chk($sformatf("wait_gnt%0d", id), gnt[id], 1'b1);
   endtask

   task automatic issue(input int id, input logic [2:0] cmd);
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      a = ADDR_W'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
      c_en[id] = 1'b1; c_cmd[id] = cmd; c_addr[id] = a;
      c_wren[id] = (cmd == 3'b000); c_wend[id] = (cmd == 3'b000); c_wdata[id] = d;
      #1;
      chk("issue_rdy", app_rdy_o[id], 1'b1);
      chk("issue_app_en", app_en, 1'b1);
      chk("issue_cmd", app_cmd, cmd);
      chk("issue_addr", app_addr, a);
      if (cmd == 3'b000) chk("issue_wdata", app_wdf_data, d);
      if (cmd == 3'b001) sb.push_back(id);
      tick();
      c_en[id] = 1'b0; c_wren[id] = 1'b0; c_wend[id] = 1'b0;
   endtask

   task automatic ret_beat();
      int e;
      logic [DATA_W-1:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      app_rd_data = d; app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty_on_return", 1'b1, 1'b0);
      end else begin
         e = sb.pop_front();
         chk("rd_valid0", rvalid[0], e == 0);
         chk("rd_valid1", rvalid[1], e == 1);
         chk("rd_end", rend[e], 1'b1);
         chk("rd_data", (e == 0) ? c0_rd_data : c1_rd_data, d);
      end
      tick();
      app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
   endtask

   initial begin
      vt[0] = '{1'b1, 3'b000, 1'b1, 1'b1, 1'b1, 1'b1,  1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1};
      vt[1] = '{1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0,  1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0};
      vt[2] = '{1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1,  1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1};
      vt[3] = '{1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0,  1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
      vt[4] = '{1'b0, 3'b001, 1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0};
      vt[5] = '{1'b1, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0};

      calib_done = 1'b1;
      clear_inputs();
      reset = 1'b1;
      #1;
      chk("rst_gnt", gnt, 2'b00);
      chk("rst_app_en", app_en, 1'b0);
      chk("rst_tag_err", tag_err, 1'b0);
      chk("rst_mask", app_wdf_mask, '0);
      tick();
      reset = 1'b0;

      // 1: single client, datapath table, writes then reads
      req[0] = 1'b1;
      #1;
      chk("t1_gnt_latency0", gnt, 2'b00);
      tick();
      chk("t1_gnt", gnt, 2'b01);
      for (int i = 0; i < 6; i++) begin
         c_en[0] = vt[i].en; c_cmd[0] = vt[i].cmd; c_wren[0] = vt[i].wren; c_wend[0] = vt[i].wren;
         c_addr[0] = ADDR_W'(i * 7 + 3); c_wdata[0] = DATA_W'(i * 1000 + 5);
         c_en[1] = vt[i].c1en; c_cmd[1] = 3'b001; c_wren[1] = 1'b1; c_addr[1] = '1;
         app_rdy = vt[i].rdy; app_wdf_rdy = vt[i].wrdy;
         #1;
         chk($sformatf("vec%0d_app_en", i), app_en, vt[i].x_en);
         chk($sformatf("vec%0d_cmd", i), app_cmd, vt[i].x_cmd);
         chk($sformatf("vec%0d_rdy", i), app_rdy_o, {vt[i].x_rdy1, vt[i].x_rdy0});
         chk($sformatf("vec%0d_wdf_rdy", i), wdf_rdy_o, {1'b0, vt[i].x_wrdy0});
         chk($sformatf("vec%0d_wren", i), app_wdf_wren, vt[i].x_wren);
         chk($sformatf("vec%0d_addr", i), app_addr, ADDR_W'(i * 7 + 3));
         chk($sformatf("vec%0d_wdata", i), app_wdf_data, DATA_W'(i * 1000 + 5));
         tick();
      end
      clear_inputs();
      req[0] = 1'b1;
      for (int i = 0; i < 4; i++) issue(0, 3'b000);
      for (int i = 0; i < 4; i++) issue(0, 3'b001);
      req[0] = 1'b0;
      for (int i = 0; i < 4; i++) ret_beat();

      // 2: simultaneous requests, round-robin with turnaround
      do_reset();
      req = 2'b11;
      tick();
      chk("t2_first_c0", gnt, 2'b01);
      req[0] = 1'b0;
      tick();
      chk("t2_turn", gnt, 2'b00);
      chk("t2_turn_app_en", app_en, 1'b0);
      req[0] = 1'b1;
      tick();
      chk("t2_idle", gnt, 2'b00);
      tick();
      chk("t2_second_c1", gnt, 2'b10);
      req[1] = 1'b0;
      tick();
      chk("t2_turn2", gnt, 2'b00);
      req[1] = 1'b1;
      tick();
      tick();
      chk("t2_third_c0", gnt, 2'b01);

      // 3: late returns route in issue order across grant change
      do_reset();
      req = 2'b11;
      wait_gnt(0);
      for (int i = 0; i < 3; i++) issue(0, 3'b001);
      req[0] = 1'b0;
      wait_gnt(1);
      for (int i = 0; i < 2; i++) issue(1, 3'b001);
      req[1] = 1'b0;
      for (int i = 0; i < 5; i++) ret_beat();

      // 4: tag FIFO full blocks reads only; one return unblocks next cycle
      do_reset();
      req[0] = 1'b1;
      wait_gnt(0);
      for (int i = 0; i < TAG_DEPTH; i++) issue(0, 3'b001);
      c_en[0] = 1'b1; c_cmd[0] = 3'b001;
      #1;
      chk("t4_full_rdy", app_rdy_o[0], 1'b0);
      chk("t4_full_app_en", app_en, 1'b0);
      c_cmd[0] = 3'b000;
      #1;
      chk("t4_full_write_en", app_en, 1'b1);
      chk("t4_full_write_rdy", app_rdy_o[0], 1'b1);
      c_cmd[0] = 3'b001;
      app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
      #1;
      chk("t4_pop_cycle_rdy", app_rdy_o[0], 1'b0);
      chk("t4_pop_route", rvalid, 2'b01);
      void'(sb.pop_front());
      tick();
      app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
      #1;
      chk("t4_after_pop_rdy", app_rdy_o[0], 1'b1);
      chk("t4_after_pop_en", app_en, 1'b1);
      sb.push_back(0);
      tick();
      c_en[0] = 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) ret_beat();
      chk("t4_no_err", tag_err, 1'b0);

      // 5: return with empty FIFO -> sticky tag_err; async reset clears it
      req[0] = 1'b0;
      app_rd_data_valid = 1'b1; app_rd_data_end = 1'b1;
      #1;
      chk("t5_no_route", rvalid, 2'b00);
      tick();
      app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;
      chk("t5_err_set", tag_err, 1'b1);
      tick(); tick(); tick();
      chk("t5_err_sticky", tag_err, 1'b1);
      req[1] = 1'b1;
      wait_gnt(1);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_async_err", tag_err, 1'b0);
      chk("t5_async_gnt", gnt, 2'b00);

      // 6: no grant before calibration; grant held when calib_done drops
      calib_done = 1'b0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_no_calib", gnt, 2'b00);
      end
      calib_done = 1'b1;
      #1;
      chk("t6_before_edge", gnt, 2'b00);
      tick();
      chk("t6_gnt_c1", gnt, 2'b10);
      calib_done = 1'b0;
      tick();
      tick();
      chk("t6_hold", gnt, 2'b10);
      req[1] = 1'b0;
      req[0] = 1'b1;
      tick(); tick(); tick();
      chk("t6_no_new_gnt", gnt, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
